// File: rtl/dram_write_buffer_if.sv
// Bundles the core-side request port and the DRAM-controller port of the posted-write buffer.
// The core_* modports face the CPU and the mem_* modports face the DRAM controller.
interface dram_write_buffer_if #(
    parameter int ADDR_W = 27,
    parameter int DATA_W = 32
);
    logic              valid_core;
    logic              rw_core;
    logic [ADDR_W-1:0] addr_core;
    logic [DATA_W-1:0] din_core;
    logic              ready_core;
    logic [DATA_W-1:0] dout_core;

    logic              mem_valid;
    logic              mem_rw;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_ready;
    logic              mem_rvalid;
    logic [DATA_W-1:0] mem_rdata;

    modport core_master (output valid_core, rw_core, addr_core, din_core,
                         input  ready_core, dout_core);
    modport core_slave  (input  valid_core, rw_core, addr_core, din_core,
                         output ready_core, dout_core);
    modport mem_master  (output mem_valid, mem_rw, mem_addr, mem_wdata,
                         input  mem_ready, mem_rvalid, mem_rdata);
    modport mem_slave   (input  mem_valid, mem_rw, mem_addr, mem_wdata,
                         output mem_ready, mem_rvalid, mem_rdata);
endinterface

// File: rtl/dram_write_buffer.sv
// Posted-write buffer between the core DRAM port and the DRAM controller: writes retire
// in one cycle and drain in order, read hits forward from the buffer, read misses drain first.
module dram_write_buffer #(
    parameter int ADDR_W = 27,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4
) (
    input  logic                      clk,
    input  logic                      rstn,
    dram_write_buffer_if.core_slave   core,
    dram_write_buffer_if.mem_master   mem,
    output logic                      buf_empty
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    localparam logic [2:0] C_IDLE   = 3'd0;
    localparam logic [2:0] C_WFULL  = 3'd1;
    localparam logic [2:0] C_RDRAIN = 3'd2;
    localparam logic [2:0] C_RREQ   = 3'd3;
    localparam logic [2:0] C_RRESP  = 3'd4;

    logic [ADDR_W-1:0] addr_q [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];
    logic [PTR_W-1:0]  head, tail, head_next;
    logic [CNT_W-1:0]  count, count_next;
    logic [2:0]        state, state_next;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_data;

    logic              pop, push, full, hit;
    logic [DATA_W-1:0] hit_data;
    logic [ADDR_W-1:0] push_addr;
    logic [DATA_W-1:0] push_data;
    logic              ready_next, dout_load;
    logic [DATA_W-1:0] dout_next;
    logic              mem_valid_next, mem_rw_next;
    logic [ADDR_W-1:0] addr_next;
    logic [DATA_W-1:0] wdata_next;

    // Scan oldest to youngest so the youngest matching entry overrides older ones.
    always_comb begin
        hit      = 1'b0;
        hit_data = '0;
        for (int k = 0; k < DEPTH; k++) begin
            if (CNT_W'(k) < count && addr_q[head + PTR_W'(k)] == core.addr_core) begin
                hit      = 1'b1;
                hit_data = data_q[head + PTR_W'(k)];
            end
        end
    end

    always_comb begin
        pop        = mem.mem_valid && mem.mem_ready && mem.mem_rw;
        full       = (count == CNT_W'(DEPTH));
        push       = 1'b0;
        push_addr  = core.addr_core;
        push_data  = core.din_core;
        state_next = state;
        ready_next = 1'b0;
        dout_load  = 1'b0;
        dout_next  = mem.mem_rdata;
        case (state)
            C_IDLE: begin
                if (core.valid_core) begin
                    if (core.rw_core) begin
                        if (!full) begin
                            push       = 1'b1;
                            ready_next = 1'b1;
                        end else begin
                            state_next = C_WFULL;
                        end
                    end else if (hit) begin
                        dout_load  = 1'b1;
                        dout_next  = hit_data;
                        ready_next = 1'b1;
                    end else begin
                        state_next = C_RDRAIN;
                    end
                end
            end
            C_WFULL: begin
                if (!full) begin
                    push       = 1'b1;
                    push_addr  = req_addr;
                    push_data  = req_data;
                    ready_next = 1'b1;
                    state_next = C_IDLE;
                end
            end
            C_RDRAIN: if (count == '0 && !mem.mem_valid) state_next = C_RREQ;
            C_RREQ:   if (mem.mem_valid && mem.mem_ready) state_next = C_RRESP;
            C_RRESP: begin
                if (mem.mem_rvalid) begin
                    dout_load  = 1'b1;
                    ready_next = 1'b1;
                    state_next = C_IDLE;
                end
            end
            default: state_next = C_IDLE;
        endcase

        head_next  = pop ? head + PTR_W'(1) : head;
        count_next = count + CNT_W'(push) - CNT_W'(pop);

        mem_valid_next = mem.mem_valid;
        mem_rw_next    = mem.mem_rw;
        addr_next      = mem.mem_addr;
        wdata_next     = mem.mem_wdata;
        if (state_next == C_RREQ || state_next == C_RRESP) begin
            if (state == C_RDRAIN) begin
                mem_valid_next = 1'b1;
                mem_rw_next    = 1'b0;
                addr_next      = req_addr;
            end else if (state_next == C_RRESP) begin
                mem_valid_next = 1'b0;
            end
        end else if (!mem.mem_valid || pop) begin
            mem_valid_next = (count_next != '0);
            mem_rw_next    = (count_next != '0);
            if (count_next != '0) begin
                // An empty buffer means the new head is the entry being pushed right now.
                if (count == CNT_W'(pop)) begin
                    addr_next  = push_addr;
                    wdata_next = push_data;
                end else begin
                    addr_next  = addr_q[head_next];
                    wdata_next = data_q[head_next];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            addr_q[tail] <= push_addr;
            data_q[tail] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            head            <= '0;
            tail            <= '0;
            count           <= '0;
            state           <= C_IDLE;
            req_addr        <= '0;
            req_data        <= '0;
            core.ready_core <= 1'b0;
            core.dout_core  <= '0;
            mem.mem_valid   <= 1'b0;
            mem.mem_rw      <= 1'b0;
            mem.mem_addr    <= '0;
            mem.mem_wdata   <= '0;
            buf_empty       <= 1'b1;
        end else begin
            if (push) tail <= tail + PTR_W'(1);
            head  <= head_next;
            count <= count_next;
            state <= state_next;
            if (state == C_IDLE && core.valid_core) begin
                req_addr <= core.addr_core;
                req_data <= core.din_core;
            end
            core.ready_core <= ready_next;
            if (dout_load) core.dout_core <= dout_next;
            mem.mem_valid <= mem_valid_next;
            mem.mem_rw    <= mem_rw_next;
            mem.mem_addr  <= addr_next;
            mem.mem_wdata <= wdata_next;
            buf_empty     <= (count_next == '0) && (state_next == C_IDLE) && !mem_valid_next;
        end
    end
endmodule

// File: tb/tb_dram_write_buffer.sv
// Self-checking bench for dram_write_buffer: a scoreboard of expected DRAM requests is checked
// by a monitor on every controller handshake, while scenario tasks check the core-side responses.
module tb_dram_write_buffer;
    localparam int AW = 27;
    localparam int DW = 32;

    typedef struct packed {
        logic          rw;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } mem_op_t;

    logic clk = 1'b0;
    logic rstn;
    logic buf_empty;
    int   n_cmp = 0;
    int   n_fail = 0;
    mem_op_t mem_exp[$];

    dram_write_buffer_if #(.ADDR_W(AW), .DATA_W(DW)) bus();

    dram_write_buffer dut (
        .clk       (clk),
        .rstn      (rstn),
        .core      (bus),
        .mem       (bus),
        .buf_empty (buf_empty)
    );

    always #5 clk = ~clk;

    // Every controller handshake must match the oldest expected request.
    always begin
        mem_op_t e;
        @(negedge clk);
        #1;
        if (rstn && bus.mem_valid && bus.mem_ready) begin
            n_cmp++;
            if (mem_exp.size() == 0) begin
                n_fail++;
                $display("[TB] FAIL mem_unexpected: got rw=%0b addr=%h data=%h, required no request",
                         bus.mem_rw, bus.mem_addr, bus.mem_wdata);
            end else begin
                e = mem_exp.pop_front();
                if (bus.mem_rw !== e.rw || bus.mem_addr !== e.addr || (e.rw && bus.mem_wdata !== e.data)) begin
                    n_fail++;
                    $display("[TB] FAIL mem_order: got rw=%0b addr=%h data=%h, required rw=%0b addr=%h data=%h",
                             bus.mem_rw, bus.mem_addr, bus.mem_wdata, e.rw, e.addr, e.data);
                end
            end
        end
    end

    task automatic core_req(input logic rw, input logic [AW-1:0] addr, input logic [DW-1:0] data);
        bus.valid_core = 1'b1;
        bus.rw_core    = rw;
        bus.addr_core  = addr;
        bus.din_core   = data;
        @(negedge clk);
        bus.valid_core = 1'b0;
    endtask

    task automatic write_req(input logic [AW-1:0] addr, input logic [DW-1:0] data);
        mem_exp.push_back('{rw: 1'b1, addr: addr, data: data});
        core_req(1'b1, addr, data);
    endtask

    task automatic drain(output bit seen);
        bus.mem_ready = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 60 && !seen; i++) begin
            if (buf_empty) seen = 1'b1;
            else @(negedge clk);
        end
        bus.mem_ready = 1'b0;
    endtask

    task automatic wait_read_issue(output bit seen);
        seen = 1'b0;
        for (int i = 0; i < 60 && !seen; i++) begin
            if (bus.mem_valid && !bus.mem_rw) seen = 1'b1;
            else @(negedge clk);
        end
    endtask

    task automatic test_reset;
        rstn = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (bus.ready_core !== 1'b0 || bus.mem_valid !== 1'b0 || bus.mem_rw !== 1'b0 || buf_empty !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL reset_ctrl: got ready=%b mem_valid=%b mem_rw=%b buf_empty=%b, required 0 0 0 1",
                     bus.ready_core, bus.mem_valid, bus.mem_rw, buf_empty);
        end
        n_cmp++;
        if (bus.mem_addr !== '0 || bus.mem_wdata !== '0 || bus.dout_core !== '0) begin
            n_fail++;
            $display("[TB] FAIL reset_data: got addr=%h wdata=%h dout=%h, required all 0",
                     bus.mem_addr, bus.mem_wdata, bus.dout_core);
        end
        rstn = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_write_hit;
        bit seen;
        write_req(27'h100, 32'hDEADBEEF);
        n_cmp++;
        if (bus.ready_core !== 1'b1) begin
            n_fail++; $display("[TB] FAIL write_latency: got ready=%b, required 1", bus.ready_core);
        end
        n_cmp++;
        if (buf_empty !== 1'b0) begin
            n_fail++; $display("[TB] FAIL buf_empty_busy: got %b, required 0", buf_empty);
        end
        core_req(1'b0, 27'h100, '0);
        n_cmp++;
        if (bus.ready_core !== 1'b1 || bus.dout_core !== 32'hDEADBEEF) begin
            n_fail++;
            $display("[TB] FAIL read_hit: got ready=%b dout=%h, required 1 deadbeef", bus.ready_core, bus.dout_core);
        end
        drain(seen);
        n_cmp++;
        if (!seen || mem_exp.size() != 0) begin
            n_fail++; $display("[TB] FAIL drain_hit: got empty=%b left=%0d, required 1 0", seen, mem_exp.size());
        end
    endtask

    task automatic test_full_stall;
        bit seen;
        for (int i = 0; i < 4; i++) begin
            write_req(AW'(32'h200 + i), DW'(32'hA0 + i));
            n_cmp++;
            if (bus.ready_core !== 1'b1) begin
                n_fail++; $display("[TB] FAIL fill_ready[%0d]: got %b, required 1", i, bus.ready_core);
            end
        end
        write_req(27'h204, 32'hA4);
        @(negedge clk);
        n_cmp++;
        if (bus.ready_core !== 1'b0) begin
            n_fail++; $display("[TB] FAIL full_stall: got ready=%b, required 0", bus.ready_core);
        end
        bus.mem_ready = 1'b1;
        @(negedge clk);
        bus.mem_ready = 1'b0;
        n_cmp++;
        if (bus.ready_core !== 1'b0) begin
            n_fail++; $display("[TB] FAIL slot_free_early: got ready=%b, required 0", bus.ready_core);
        end
        @(negedge clk);
        n_cmp++;
        if (bus.ready_core !== 1'b1) begin
            n_fail++; $display("[TB] FAIL slot_free_ready: got ready=%b, required 1", bus.ready_core);
        end
        drain(seen);
        n_cmp++;
        if (!seen || mem_exp.size() != 0) begin
            n_fail++; $display("[TB] FAIL drain_full: got empty=%b left=%0d, required 1 0", seen, mem_exp.size());
        end
    endtask

    task automatic test_read_miss;
        bit seen;
        write_req(27'h10, 32'h1);
        write_req(27'h20, 32'h2);
        mem_exp.push_back('{rw: 1'b0, addr: 27'h30, data: '0});
        core_req(1'b0, 27'h30, '0);
        n_cmp++;
        if (bus.ready_core !== 1'b0) begin
            n_fail++; $display("[TB] FAIL miss_no_ready: got ready=%b, required 0", bus.ready_core);
        end
        bus.mem_ready = 1'b1;
        wait_read_issue(seen);
        n_cmp++;
        if (!seen) begin
            n_fail++; $display("[TB] FAIL miss_read_issue: got no read request, required one");
        end
        @(negedge clk);
        bus.mem_ready  = 1'b0;
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = 32'h12345678;
        @(negedge clk);
        bus.mem_rvalid = 1'b0;
        n_cmp++;
        if (bus.ready_core !== 1'b1 || bus.dout_core !== 32'h12345678) begin
            n_fail++;
            $display("[TB] FAIL miss_data: got ready=%b dout=%h, required 1 12345678", bus.ready_core, bus.dout_core);
        end
        n_cmp++;
        if (mem_exp.size() != 0) begin
            n_fail++; $display("[TB] FAIL miss_sequence: got %0d requests left, required 0", mem_exp.size());
        end
    endtask

    task automatic test_forward;
        bit seen;
        write_req(27'h40, 32'h1);
        write_req(27'h40, 32'h2);
        core_req(1'b0, 27'h40, '0);
        n_cmp++;
        if (bus.ready_core !== 1'b1 || bus.dout_core !== 32'h2) begin
            n_fail++;
            $display("[TB] FAIL youngest_hit: got ready=%b dout=%h, required 1 00000002", bus.ready_core, bus.dout_core);
        end
        drain(seen);
        n_cmp++;
        if (!seen) begin
            n_fail++; $display("[TB] FAIL drain_fwd: got empty=0, required 1");
        end
        write_req(27'h50, 32'h7);
        bus.mem_ready = 1'b1;
        core_req(1'b0, 27'h50, '0);
        bus.mem_ready = 1'b0;
        n_cmp++;
        if (bus.ready_core !== 1'b1 || bus.dout_core !== 32'h7) begin
            n_fail++;
            $display("[TB] FAIL hit_on_pop: got ready=%b dout=%h, required 1 00000007", bus.ready_core, bus.dout_core);
        end
        n_cmp++;
        if (mem_exp.size() != 0) begin
            n_fail++; $display("[TB] FAIL hit_on_pop_drain: got %0d requests left, required 0", mem_exp.size());
        end
    endtask

    task automatic test_reset_rresp;
        bit seen;
        bit stray;
        bus.mem_ready = 1'b1;
        mem_exp.push_back('{rw: 1'b0, addr: 27'h60, data: '0});
        core_req(1'b0, 27'h60, '0);
        wait_read_issue(seen);
        @(negedge clk);
        bus.mem_ready = 1'b0;
        rstn = 1'b0;
        #1;
        n_cmp++;
        if (!seen || bus.ready_core !== 1'b0 || bus.mem_valid !== 1'b0 || bus.dout_core !== '0 ||
            bus.mem_addr !== '0 || buf_empty !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL reset_in_rresp: got issued=%b ready=%b mem_valid=%b dout=%h addr=%h empty=%b, required 1 0 0 0 0 1",
                     seen, bus.ready_core, bus.mem_valid, bus.dout_core, bus.mem_addr, buf_empty);
        end
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = 32'hBAD0BAD0;
        @(negedge clk);
        bus.mem_rvalid = 1'b0;
        stray = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (bus.ready_core) stray = 1'b1;
            @(negedge clk);
        end
        n_cmp++;
        if (stray || bus.dout_core !== '0) begin
            n_fail++;
            $display("[TB] FAIL stray_rvalid: got ready_seen=%b dout=%h, required 0 00000000", stray, bus.dout_core);
        end
    endtask

    task automatic test_back_to_back;
        bit seen;
        for (int i = 0; i < 4; i++) write_req(AW'(32'h300 + i), DW'(32'hC0 + i));
        bus.mem_ready = 1'b1;
        write_req(27'h304, 32'hC4);
        bus.mem_ready = 1'b0;
        n_cmp++;
        if (bus.ready_core !== 1'b0) begin
            n_fail++; $display("[TB] FAIL pop_push_full: got ready=%b, required 0", bus.ready_core);
        end
        @(negedge clk);
        n_cmp++;
        if (bus.ready_core !== 1'b1) begin
            n_fail++; $display("[TB] FAIL pop_push_ready: got ready=%b, required 1", bus.ready_core);
        end
        write_req(27'h305, 32'hC5);
        n_cmp++;
        if (bus.ready_core !== 1'b0) begin
            n_fail++; $display("[TB] FAIL refilled_full: got ready=%b, required 0", bus.ready_core);
        end
        drain(seen);
        n_cmp++;
        if (!seen || mem_exp.size() != 0) begin
            n_fail++; $display("[TB] FAIL drain_order: got empty=%b left=%0d, required 1 0", seen, mem_exp.size());
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        bus.valid_core = 1'b0;
        bus.rw_core    = 1'b0;
        bus.addr_core  = '0;
        bus.din_core   = '0;
        bus.mem_ready  = 1'b0;
        bus.mem_rvalid = 1'b0;
        bus.mem_rdata  = '0;
        test_reset();
        test_write_hit();
        test_full_stall();
        test_read_miss();
        test_forward();
        test_reset_rresp();
        test_back_to_back();
        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
